// File: rtl/eu_operand_collector.sv
// Operand collector between an EU instruction queue and its ALU: captures one
// instruction, reads its sources serially over an in-order read port, then issues.
module eu_operand_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 5,
    parameter int OPC_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [OPC_WIDTH-1:0]  instr_opc_i,
    input  logic [TAG_WIDTH-1:0]  instr_src_a_i,
    input  logic [TAG_WIDTH-1:0]  instr_src_b_i,
    input  logic                  instr_use_imm_b_i,
    input  logic [DATA_WIDTH-1:0] instr_imm_i,
    input  logic [TAG_WIDTH-1:0]  instr_dest_i,
    output logic                  rd_req_valid_o,
    output logic [TAG_WIDTH-1:0]  rd_req_tag_o,
    input  logic                  rd_req_ready_i,
    input  logic                  rd_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_resp_data_i,
    output logic                  alu_valid_o,
    input  logic                  alu_ready_i,
    output logic [OPC_WIDTH-1:0]  alu_opc_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [TAG_WIDTH-1:0]  alu_dest_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {IDLE, REQ_A, REQ_B, WAIT, ISSUE} state_e;

    state_e                state_q, state_d;
    logic [OPC_WIDTH-1:0]  opc_q, opc_d;
    logic [TAG_WIDTH-1:0]  src_a_q, src_a_d, src_b_q, src_b_d, dest_q, dest_d;
    logic                  use_imm_q, use_imm_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]            outst_q, outst_d, rcvd_q, rcvd_d;
    logic                  err_q, err_d;

    logic       req_fire, resp_ok;
    logic [1:0] need;

    assign req_fire = ((state_q == REQ_A) || (state_q == REQ_B)) && rd_req_ready_i;
    // A response with nothing outstanding is dropped so the counter never underflows.
    assign resp_ok  = rd_resp_valid_i && (outst_q != 2'd0);
    assign need     = use_imm_q ? 2'd1 : 2'd2;

    assign instr_ready_o  = (state_q == IDLE);
    assign rd_req_valid_o = (state_q == REQ_A) || (state_q == REQ_B);
    assign rd_req_tag_o   = (state_q == REQ_B) ? src_b_q :
                            (state_q == REQ_A) ? src_a_q : '0;
    assign alu_valid_o    = (state_q == ISSUE);
    assign alu_opc_o      = opc_q;
    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign alu_dest_o     = dest_q;
    assign err_o          = err_q;

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        dest_d    = dest_q;
        use_imm_d = use_imm_q;
        a_d       = a_q;
        b_d       = b_q;
        rcvd_d    = rcvd_q;
        outst_d   = outst_q + {1'b0, req_fire} - {1'b0, resp_ok};
        err_d     = err_q | (rd_resp_valid_i && (outst_q == 2'd0));

        // Responses return in request order: first fills A, second fills B.
        if (resp_ok) begin
            if (rcvd_q == 2'd0) a_d = rd_resp_data_i;
            else                b_d = rd_resp_data_i;
            rcvd_d = rcvd_q + 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (instr_valid_i) begin
                    opc_d     = instr_opc_i;
                    src_a_d   = instr_src_a_i;
                    src_b_d   = instr_src_b_i;
                    dest_d    = instr_dest_i;
                    use_imm_d = instr_use_imm_b_i;
                    if (instr_use_imm_b_i) b_d = instr_imm_i;
                    rcvd_d    = 2'd0;
                    state_d   = REQ_A;
                end
            end
            REQ_A: if (rd_req_ready_i) state_d = use_imm_q ? WAIT : REQ_B;
            REQ_B: if (rd_req_ready_i) state_d = WAIT;
            // Look at next-cycle counts so issue follows the last response directly.
            WAIT:  if ((rcvd_d == need) && (outst_d == 2'd0)) state_d = ISSUE;
            ISSUE: if (alu_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            opc_q     <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dest_q    <= '0;
            use_imm_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            outst_q   <= 2'd0;
            rcvd_q    <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            dest_q    <= dest_d;
            use_imm_q <= use_imm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            outst_q   <= outst_d;
            rcvd_q    <= rcvd_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_eu_operand_collector.sv
// Bench for eu_operand_collector: directed scenarios plus randomized instructions,
// with a register-file model supplying in-order read responses.
module tb_eu_operand_collector;
    localparam int DW = 16;
    localparam int TW = 5;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          instr_valid_i, instr_ready_o, instr_use_imm_b_i;
    logic [OW-1:0] instr_opc_i, alu_opc_o;
    logic [TW-1:0] instr_src_a_i, instr_src_b_i, instr_dest_i, rd_req_tag_o, alu_dest_o;
    logic [DW-1:0] instr_imm_i, rd_resp_data_i, alu_a_o, alu_b_o;
    logic          rd_req_valid_o, rd_req_ready_i, rd_resp_valid_i;
    logic          alu_valid_o, alu_ready_i, err_o;

    eu_operand_collector #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OPC_WIDTH(OW)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_opc_i(instr_opc_i), .instr_src_a_i(instr_src_a_i),
        .instr_src_b_i(instr_src_b_i), .instr_use_imm_b_i(instr_use_imm_b_i),
        .instr_imm_i(instr_imm_i), .instr_dest_i(instr_dest_i),
        .rd_req_valid_o(rd_req_valid_o), .rd_req_tag_o(rd_req_tag_o),
        .rd_req_ready_i(rd_req_ready_i), .rd_resp_valid_i(rd_resp_valid_i),
        .rd_resp_data_i(rd_resp_data_i), .alu_valid_o(alu_valid_o),
        .alu_ready_i(alu_ready_i), .alu_opc_o(alu_opc_o), .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o), .alu_dest_o(alu_dest_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int            n_asrt = 0;
    int            n_fail = 0;
    logic [DW-1:0] rf [32];
    logic          exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [OW-1:0] opc, input logic [TW-1:0] sa, input logic [TW-1:0] sb,
                           input logic ui, input logic [DW-1:0] imm, input logic [TW-1:0] dst);
        instr_valid_i = 1'b1; instr_opc_i = opc; instr_src_a_i = sa; instr_src_b_i = sb;
        instr_use_imm_b_i = ui; instr_imm_i = imm; instr_dest_i = dst;
    endtask

    task automatic scramble();
        instr_valid_i = 1'b0; instr_opc_i = OW'($urandom); instr_src_a_i = TW'($urandom);
        instr_src_b_i = TW'($urandom); instr_use_imm_b_i = 1'($urandom);
        instr_imm_i = DW'($urandom); instr_dest_i = TW'($urandom);
    endtask

    // One instruction end to end. Stalls: request-ready low for st_a/st_b cycles of
    // each request, ALU-ready low for alu_st cycles; each response dly cycles after
    // its acceptance (kept in order). exp_issue < 0 skips the exact handshake cycle check.
    task automatic run_instr(input logic [OW-1:0] opc, input logic [TW-1:0] sa, input logic [TW-1:0] sb,
                             input logic ui, input logic [DW-1:0] imm, input logic [TW-1:0] dst,
                             input int st_a, input int st_b, input int dly, input int alu_st,
                             input int exp_issue);
        int            due[$];
        logic [DW-1:0] dq[$];
        int            nreq, stall, astall, last_due, last_resp, first_v, cyc, d;
        bit            done;
        logic [DW-1:0] exp_a, exp_b;
        nreq = 0; stall = 0; astall = 0; last_due = 0; last_resp = -100; first_v = -1; done = 0;
        exp_a = rf[sa];
        exp_b = ui ? imm : rf[sb];
        chk("idle_ready", 32'(instr_ready_o), 32'd1);
        present(opc, sa, sb, ui, imm, dst);
        rd_req_ready_i = 1'b0; alu_ready_i = 1'b0; rd_resp_valid_i = 1'b0;
        tick();
        cyc = 1;
        scramble();
        while (!done && cyc < 300) begin
            rd_resp_valid_i = (due.size() > 0) && (due[0] == cyc);
            rd_resp_data_i  = rd_resp_valid_i ? dq[0] : DW'($urandom);
            rd_req_ready_i  = (stall >= ((nreq == 0) ? st_a : st_b));
            alu_ready_i     = (astall >= alu_st);
            chk("busy_not_ready", 32'(instr_ready_o), 32'd0);
            chk("err_flag", 32'(err_o), 32'(exp_err));
            if (rd_req_valid_o) begin
                chk("req_tag", 32'(rd_req_tag_o), 32'((nreq == 0) ? sa : sb));
                chk("req_extra", 32'(nreq < (ui ? 1 : 2)), 32'd1);
            end
            if (alu_valid_o) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("issue_time", 32'(cyc), 32'(last_resp + 1));
                end
                chk("alu_opc", 32'(alu_opc_o), 32'(opc));
                chk("alu_a", 32'(alu_a_o), 32'(exp_a));
                chk("alu_b", 32'(alu_b_o), 32'(exp_b));
                chk("alu_dest", 32'(alu_dest_o), 32'(dst));
            end
            if (rd_resp_valid_i) begin
                void'(due.pop_front());
                void'(dq.pop_front());
                last_resp = cyc;
            end
            if (rd_req_valid_o && rd_req_ready_i) begin
                dq.push_back((nreq == 0) ? rf[sa] : rf[sb]);
                d = cyc + dly;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                due.push_back(d);
                nreq++;
                stall = 0;
            end else if (rd_req_valid_o) begin
                stall++;
            end
            if (alu_valid_o) begin
                if (alu_ready_i) begin
                    done = 1;
                    if (exp_issue >= 0) chk("issue_cycle", 32'(cyc), 32'(exp_issue));
                end else begin
                    astall++;
                end
            end
            tick();
            cyc++;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        chk("num_reqs", 32'(nreq), 32'(ui ? 1 : 2));
        rd_req_ready_i = 1'b0; alu_ready_i = 1'b0; rd_resp_valid_i = 1'b0;
        chk("back_idle", 32'(instr_ready_o), 32'd1);
        chk("single_issue", 32'(alu_valid_o), 32'd0);
        chk("idle_no_req", 32'(rd_req_valid_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = DW'($urandom);
        reset_n = 1'b0;
        scramble();
        rd_req_ready_i = 1'b0; rd_resp_valid_i = 1'b0; rd_resp_data_i = '0; alu_ready_i = 1'b0;
        repeat (2) tick();
        chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_req_valid", 32'(rd_req_valid_o), 32'd0);
        chk("rst_alu_valid", 32'(alu_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_alu_a", 32'(alu_a_o), 32'd0);
        chk("rst_alu_dest", 32'(alu_dest_o), 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset while requesting A
        present(4'd1, 5'd6, 5'd8, 1'b0, 16'h0, 5'd3);
        tick();
        scramble();
        chk("reqa_valid", 32'(rd_req_valid_o), 32'd1);
        chk("reqa_tag", 32'(rd_req_tag_o), 32'd6);
        reset_n = 1'b0;
        tick();
        chk("midrst_instr_ready", 32'(instr_ready_o), 32'd1);
        chk("midrst_req_valid", 32'(rd_req_valid_o), 32'd0);
        chk("midrst_alu_valid", 32'(alu_valid_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic two-operand, zero wait
        rf[2] = 16'h1111; rf[7] = 16'h2222;
        run_instr(4'd3, 5'd2, 5'd7, 1'b0, 16'h0, 5'd9, 0, 0, 1, 0, 4);
        // Immediate B, single read
        rf[4] = 16'hABCD;
        run_instr(4'd5, 5'd4, 5'd11, 1'b1, 16'h00FF, 5'd1, 0, 0, 1, 0, 3);
        // Backpressure on B request and on ALU
        run_instr(4'd7, 5'd10, 5'd12, 1'b0, 16'h0, 5'd13, 0, 3, 1, 4, 11);
        // Both requests back-to-back, long response latency
        run_instr(4'd2, 5'd14, 5'd15, 1'b0, 16'h0, 5'd16, 0, 0, 5, 0, 8);
        // Same source twice: two separate reads
        run_instr(4'd9, 5'd20, 5'd20, 1'b0, 16'h0, 5'd21, 0, 0, 2, 1, -1);

        // Late response after reset mid-operation
        present(4'd1, 5'd3, 5'd5, 1'b0, 16'h0, 5'd2);
        rd_req_ready_i = 1'b1;
        tick();
        scramble();
        tick();
        rd_req_ready_i = 1'b0;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        rd_resp_valid_i = 1'b1;
        rd_resp_data_i = 16'h5A5A;
        tick();
        rd_resp_valid_i = 1'b0;
        exp_err = 1'b1;
        chk("late_resp_err", 32'(err_o), 32'd1);
        chk("late_resp_idle", 32'(instr_ready_o), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_err = 1'b0;
        chk("err_cleared", 32'(err_o), 32'd0);
        tick();

        // Spurious response in IDLE, then a normal instruction
        rd_resp_valid_i = 1'b1;
        rd_resp_data_i = 16'hDEAD;
        tick();
        rd_resp_valid_i = 1'b0;
        exp_err = 1'b1;
        chk("spur_err", 32'(err_o), 32'd1);
        tick();
        chk("spur_err_sticky", 32'(err_o), 32'd1);
        run_instr(4'd6, 5'd17, 5'd18, 1'b0, 16'h0, 5'd19, 0, 0, 1, 0, 4);

        // Randomized instructions and timing
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 32; i++) rf[i] = DW'($urandom);
            run_instr(OW'($urandom), TW'($urandom), TW'($urandom), 1'($urandom), DW'($urandom),
                      TW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(1, 4), $urandom_range(0, 3), -1);
        end
        chk("final_err_sticky", 32'(err_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
